// File: rtl/pixel_writer.sv
// pixel_writer: sink stage after per-pixel shading. Buffers shaded pixels in a
// small circular FIFO and drains them into the depth buffer and framebuffer.
// Build option: define PW_DEPTH_TEST_EN to enable the read-compare-write depth
// test (IDLE->RD->CMP, 1 pixel / 3 cycles). Without it every pixel is written
// straight to the framebuffer (IDLE->WR, 1 pixel / 2 cycles) and the depth
// buffer port is held idle.
module pixel_writer #(
  parameter int WIDTH = 640,
  parameter int DEPTH = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [9:0]  in_x,
  input  logic [8:0]  in_y,
  input  logic [15:0] in_z,
  input  logic [15:0] in_color,
  output logic        in_ready,
  output logic [18:0] z_addr,
  input  logic [15:0] z_rdata,
  output logic [15:0] z_wdata,
  output logic        z_we,
  output logic [18:0] fb_addr,
  output logic [15:0] fb_wdata,
  output logic        fb_we,
  output logic        busy,
  output logic        overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
`ifdef PW_DEPTH_TEST_EN
  localparam int ENTRY_W = 10 + 9 + 16 + 16;
`else
  localparam int ENTRY_W = 10 + 9 + 16;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    CMP  = 2'd2,
    WR   = 2'd3
  } state_t;

  state_t state, state_next;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               push, pop;
  logic [ENTRY_W-1:0] wr_entry, head;
  logic [9:0]         head_x;
  logic [8:0]         head_y;
  logic [15:0]        head_color;
  logic [18:0]        head_addr;

  logic [18:0]        lat_addr;
  logic [15:0]        lat_color;
  logic [18:0]        fb_addr_q;
  logic [15:0]        fb_wdata_q;

  // A pop never frees a slot in the same cycle, so in_ready depends on count only
  assign in_ready = (count < CNT_W'(DEPTH));
  assign push     = in_valid && in_ready;
  assign busy     = (count != '0) || (state != IDLE);

`ifdef PW_DEPTH_TEST_EN
  logic [15:0] head_z;
  logic [15:0] lat_z;
  logic [18:0] z_addr_q;
  logic [15:0] z_wdata_q;
  assign wr_entry = {in_x, in_y, in_color, in_z};
  assign head_z   = head[15:0];
`else
  logic unused_inputs;
  assign wr_entry      = {in_x, in_y, in_color};
  assign unused_inputs = ^{in_z, z_rdata};
`endif

  assign head       = mem[rd_ptr];
  assign head_x     = head[ENTRY_W-1 -: 10];
  assign head_y     = head[ENTRY_W-11 -: 9];
  assign head_color = head[ENTRY_W-20 -: 16];
  // Linear framebuffer address, deliberately truncated to 19 bits with no range check
  assign head_addr  = 19'(head_y) * 19'(WIDTH) + 19'(head_x);

  // FIFO storage: entries are not reset, count/pointers decide what is valid
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at a power-of-two depth
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky drop flag: only reset clears it
  always_ff @(posedge clock) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (in_valid && !in_ready) begin
      overflow <= 1'b1;
    end
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state, pop and write strobes
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    z_we       = 1'b0;
    fb_we      = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop = 1'b1;
`ifdef PW_DEPTH_TEST_EN
          state_next = RD;
`else
          state_next = WR;
`endif
        end
      end
`ifdef PW_DEPTH_TEST_EN
      RD: begin
        state_next = CMP;
      end
      CMP: begin
        if (lat_z < z_rdata) begin
          z_we  = 1'b1;
          fb_we = 1'b1;
        end
        state_next = IDLE;
      end
`else
      WR: begin
        fb_we      = 1'b1;
        state_next = IDLE;
      end
`endif
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Latch the FIFO head at pop and remember the last driven addresses/data
  always_ff @(posedge clock) begin
    if (reset) begin
      lat_addr   <= '0;
      lat_color  <= '0;
      fb_addr_q  <= '0;
      fb_wdata_q <= '0;
`ifdef PW_DEPTH_TEST_EN
      lat_z      <= '0;
      z_addr_q   <= '0;
      z_wdata_q  <= '0;
`endif
    end else begin
      if (pop) begin
        lat_addr  <= head_addr;
        lat_color <= head_color;
`ifdef PW_DEPTH_TEST_EN
        lat_z     <= head_z;
`endif
      end
      if (fb_we) begin
        fb_addr_q  <= lat_addr;
        fb_wdata_q <= lat_color;
      end
`ifdef PW_DEPTH_TEST_EN
      if (state == RD) begin
        z_addr_q <= lat_addr;
      end
      if (z_we) begin
        z_wdata_q <= lat_z;
      end
`endif
    end
  end

  // Memory ports show the live pixel while active and hold their last value otherwise
  always_comb begin
    fb_addr  = fb_we ? lat_addr : fb_addr_q;
    fb_wdata = fb_we ? lat_color : fb_wdata_q;
`ifdef PW_DEPTH_TEST_EN
    z_addr   = (state == RD) ? lat_addr : z_addr_q;
    z_wdata  = z_we ? lat_z : z_wdata_q;
`else
    z_addr   = '0;
    z_wdata  = '0;
`endif
  end

endmodule
